// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM state type and
// default vector / increment constants.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_S_BOOT = 2'd0,
    PC_S_RUN  = 2'd1,
    PC_S_HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned PC_INC          = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC / next-state priority mux for pc_unit.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect traps).
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned       XLEN        = 32,
  parameter logic [XLEN-1:0]   TRAP_VECTOR = XLEN'(PC_TRAP_VECTOR),
  parameter int unsigned       INC         = PC_INC
) (
  input  pc_state_t            state,
  input  logic [XLEN-1:0]      pc,
  input  logic                 fetch,
  input  logic                 trap_req,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_target,
  input  logic                 halt_req,
  input  logic                 resume_req,
  output logic [XLEN-1:0]      pc_next,
  output pc_state_t            state_next,
  output logic                 count_fetch,
  output logic                 misalign
);

  logic [XLEN-1:0] redir_pc;
  logic            redir_bad;

  // Resolve the effective redirect destination (trap or force-align).
  always_comb begin
`ifdef PC_MISALIGN_TRAP_EN
    redir_bad = |redirect_target[1:0];
    redir_pc  = redir_bad ? TRAP_VECTOR : redirect_target;
`else
    redir_bad = 1'b0;
    redir_pc  = redirect_target & {{(XLEN-2){1'b1}}, 2'b00};
`endif
  end

  // Priority selection: trap > redirect > halt > sequential advance.
  always_comb begin
    pc_next     = pc;
    state_next  = state;
    count_fetch = 1'b0;
    misalign    = 1'b0;
    case (state)
      PC_S_BOOT: state_next = PC_S_RUN;
      PC_S_RUN: begin
        // A handshake is still counted under trap/redirect; only a plain halt suppresses it.
        count_fetch = fetch & (trap_req | redirect_valid | ~halt_req);
        if (trap_req) begin
          pc_next = TRAP_VECTOR;
        end else if (redirect_valid) begin
          pc_next  = redir_pc;
          misalign = redir_bad;
        end else if (halt_req) begin
          state_next = PC_S_HALT;
        end else if (fetch) begin
          pc_next = pc + XLEN'(INC);
        end
      end
      PC_S_HALT: begin
        if (trap_req) begin
          pc_next    = TRAP_VECTOR;
          state_next = PC_S_RUN;
        end else begin
          if (redirect_valid) begin
            pc_next  = redir_pc;
            misalign = redir_bad;
          end
          if (resume_req) state_next = PC_S_RUN;
        end
      end
      default: state_next = PC_S_BOOT;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch address register, handshake advance,
// redirect/trap/halt handling and accepted-fetch counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect traps).
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR),
  parameter int unsigned       INC          = PC_INC,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_target,
  input  logic                 trap_req,
  input  logic                 halt_req,
  input  logic                 resume_req,
  input  logic                 fetch_ready,
  output logic [XLEN-1:0]      pc_out,
  output logic                 pc_valid,
  output logic [XLEN-1:0]      pc_prev,
  output logic                 misalign_err,
  output logic                 halted,
  output logic [CNT_W-1:0]     fetch_count
);

  pc_state_t       state;
  pc_state_t       state_next;
  logic [XLEN-1:0] pc_next;
  logic            count_fetch;
  logic            misalign;
  logic            fetch;

  assign fetch = pc_valid & fetch_ready & ~stall;

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INC         (INC)
  ) u_next_sel (
    .state           (state),
    .pc              (pc_out),
    .fetch           (fetch),
    .trap_req        (trap_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume_req      (resume_req),
    .pc_next         (pc_next),
    .state_next      (state_next),
    .count_fetch     (count_fetch),
    .misalign        (misalign)
  );

  // State, PC and status registers; valid/halted decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PC_S_BOOT;
      pc_out       <= RESET_VECTOR;
      pc_prev      <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_next;
      pc_out       <= pc_next;
      pc_valid     <= (state_next == PC_S_RUN);
      halted       <= (state_next == PC_S_HALT);
      misalign_err <= misalign;
      if (count_fetch) begin
        pc_prev     <= pc_out;
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed table plus randomized run
// against a rule-level reference model.
module tb_pc_unit;

  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid, trap_req, halt_req, resume_req, fetch_ready;
  logic [31:0] redirect_target;
  logic [31:0] pc_out, pc_prev, fetch_count;
  logic        pc_valid, misalign_err, halted;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .halt_req        (halt_req),
    .resume_req      (resume_req),
    .fetch_ready     (fetch_ready),
    .pc_out          (pc_out),
    .pc_valid        (pc_valid),
    .pc_prev         (pc_prev),
    .misalign_err    (misalign_err),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  typedef struct {
    logic        stall, rv;
    logic [31:0] tgt;
    logic        trap, halt, resume, ready;
    logic [31:0] e_pc, e_prev;
    logic        e_valid, e_halted;
    logic [31:0] e_cnt;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, rv, input logic [31:0] tgt,
                              input logic tr, hl, rs, rd,
                              input logic [31:0] e_pc, e_prev,
                              input logic e_valid, e_halted,
                              input logic [31:0] e_cnt, input logic e_mis);
    vec_t v;
    v.stall = st; v.rv = rv; v.tgt = tgt; v.trap = tr; v.halt = hl;
    v.resume = rs; v.ready = rd; v.e_pc = e_pc; v.e_prev = e_prev;
    v.e_valid = e_valid; v.e_halted = e_halted; v.e_cnt = e_cnt; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, e_prev,
                         input logic e_valid, e_halted, input logic [31:0] e_cnt,
                         input logic e_mis);
    chk({tag, ".pc_out"},       pc_out,              e_pc);
    chk({tag, ".pc_prev"},      pc_prev,             e_prev);
    chk({tag, ".pc_valid"},     32'(pc_valid),       32'(e_valid));
    chk({tag, ".halted"},       32'(halted),         32'(e_halted));
    chk({tag, ".fetch_count"},  fetch_count,         e_cnt);
    chk({tag, ".misalign_err"}, 32'(misalign_err),   32'(e_mis));
  endtask

  task automatic drive(input logic st, rv, input logic [31:0] tgt,
                       input logic tr, hl, rs, rd);
    stall = st; redirect_valid = rv; redirect_target = tgt;
    trap_req = tr; halt_req = hl; resume_req = rs; fetch_ready = rd;
  endtask

  // Reference model state
  logic [31:0] m_pc, m_prev, m_cnt;
  bit          m_boot, m_halt, m_mis;

  function automatic void eff_target(input logic [31:0] tgt, output logic [31:0] pc, output bit bad);
    logic [1:0] lo;
    lo = tgt[1:0];
`ifdef PC_MISALIGN_TRAP_EN
    bad = (lo != 2'b00);
    pc  = bad ? TV : tgt;
`else
    bad = 1'b0;
    pc  = tgt - 32'(lo);
`endif
  endfunction

  task automatic model_step(input logic st, rv, input logic [31:0] tgt,
                            input logic tr, hl, rs, rd);
    logic [31:0] epc;
    bit          bad;
    eff_target(tgt, epc, bad);
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt) begin
      if (rd && !st && !(hl && !tr && !rv)) begin
        m_prev = m_pc;
        m_cnt  = m_cnt + 1;
        m_pc   = m_pc + 4;
      end
      if (tr) m_pc = TV;
      else if (rv) begin m_pc = epc; m_mis = bad; end
      else if (hl) m_halt = 1'b1;
    end else begin
      if (tr) begin
        m_pc = TV; m_halt = 1'b0;
      end else begin
        if (rv) begin m_pc = epc; m_mis = bad; end
        if (rs) m_halt = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] t12_pc;
    logic        t12_mis;
    logic        r_st, r_rv, r_tr, r_hl, r_rs, r_rd;
    logic [31:0] r_tgt;

`ifdef PC_MISALIGN_TRAP_EN
    t12_pc = 32'h100; t12_mis = 1'b1;
`else
    t12_pc = 32'h200; t12_mis = 1'b0;
`endif
    //             st rv tgt           tr hl rs rd  pc            prev          v  h  cnt mis
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0, 1, 32'h4,        32'h0,        1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0, 1, 32'h8,        32'h4,        1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0, 1, 32'hC,        32'h8,        1, 0, 3, 0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 0, 1, 32'hC,        32'h8,        1, 0, 3, 0));
    tbl.push_back(mk(1, 1, 32'h200,      0, 0, 0, 1, 32'h200,      32'h8,        1, 0, 3, 0));
    tbl.push_back(mk(0, 1, 32'h80,       1, 0, 0, 0, 32'h100,      32'h8,        1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h100,      32'h8,        0, 1, 3, 0));
    tbl.push_back(mk(0, 1, 32'h40,       0, 0, 0, 0, 32'h40,       32'h8,        0, 1, 3, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 1, 0, 32'h40,       32'h8,        1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0, 1, 32'h44,       32'h40,       1, 0, 4, 0));
    tbl.push_back(mk(0, 1, 32'h202,      0, 0, 0, 0, t12_pc,       32'h40,       1, 0, 4, t12_mis));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, t12_pc,       32'h40,       1, 0, 4, 0));
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFC,0, 0, 0, 0, 32'hFFFF_FFFC,32'h40,       1, 0, 4, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'hFFFF_FFFC,1, 0, 5, 0));
    tbl.push_back(mk(0, 1, 32'h300,      0, 0, 0, 1, 32'h300,      32'h0,        1, 0, 6, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h300,      32'h0,        0, 1, 6, 0));

    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h0, 0, 0, 32'h0, 0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].rv, tbl[i].tgt, tbl[i].trap, tbl[i].halt,
            tbl[i].resume, tbl[i].ready);
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_prev, tbl[i].e_valid,
              tbl[i].e_halted, tbl[i].e_cnt, tbl[i].e_mis);
    end

    // Reset asserted mid-halt takes effect without a clock edge.
    drive(0, 1, 32'h500, 0, 0, 1, 1);
    #2 reset = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 32'h0, 32'h0, 0, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 0, 0, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all("boot", 32'h0, 32'h0, 1, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    chk_all("first_fetch", 32'h4, 32'h0, 1, 0, 32'h1, 0);

    // Randomized run against the reference model.
    reset = 1'b0;
    #2 reset = 1'b1;
    m_pc = 32'h0; m_prev = 32'h0; m_cnt = 32'h0;
    m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0;
    for (int n = 0; n < 500; n++) begin
      r_tr  = ($urandom_range(0, 15) == 0);
      r_rv  = ($urandom_range(0, 7) == 0);
      r_hl  = ($urandom_range(0, 11) == 0);
      r_rs  = ($urandom_range(0, 3) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 3) != 0);
      r_tgt = $urandom;
      if ($urandom_range(0, 1) == 0) r_tgt[1:0] = 2'b00;
      if (r_hl && !r_tr && !r_rv) r_rd = 1'b0;
      drive(r_st, r_rv, r_tgt, r_tr, r_hl, r_rs, r_rd);
      model_step(r_st, r_rv, r_tgt, r_tr, r_hl, r_rs, r_rd);
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", n), m_pc, m_prev, !m_boot && !m_halt, m_halt, m_cnt, m_mis);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V core, successor to the fixed single-increment PC. Holds the fetch address, advances it on a valid/ready handshake with the fetch stage, and accepts stall, branch/jump redirect, trap entry and halt/resume requests. It sits between the execute/control logic and instruction fetch, and counts accepted fetches for performance monitoring.

## Interface

- XLEN, 32, address and PC width in bits (≥ 8)
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits)
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap entry (XLEN bits)
- INC, 4, byte increment per accepted fetch
- CNT_W, 32, fetch_count width

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC; blocks sequential advance only
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  XLEN  redirect destination
- trap_req  in  1  enter trap handler
- halt_req  in  1  request halt
- resume_req  in  1  leave halt
- fetch_ready  in  1  fetch stage accepts pc_out
- pc_out  out  XLEN  current fetch address
- pc_valid  out  1  pc_out is a valid fetch request
- pc_prev  out  XLEN  address of last accepted fetch
- misalign_err  out  1  one-cycle pulse on misaligned redirect
- halted  out  1  unit is in HALT
- fetch_count  out  CNT_W  number of accepted fetches

## Operation

- States: BOOT, RUN, HALT. Encoded as 2 bits.
- Reset (reset=0): state=BOOT, pc_out=RESET_VECTOR, pc_prev=RESET_VECTOR, pc_valid=0, misalign_err=0, halted=0, fetch_count=0. Reset can be asserted at any time, including mid-halt or mid-redirect, and clears all state immediately.
- BOOT: unconditionally moves to RUN on the next edge; pc_valid becomes 1 and pc_out stays RESET_VECTOR. Inputs are ignored in BOOT.
- RUN priority, highest first: trap_req, redirect_valid, halt_req, advance.
  - trap_req: pc_out <= TRAP_VECTOR, state stays RUN.
  - redirect_valid: pc_out <= redirect_target. Any unaccepted request is discarded.
  - halt_req: state <= HALT, pc_valid <= 0, pc_out holds.
  - advance: on fetch = pc_valid & fetch_ready & ~stall, pc_prev <= pc_out, pc_out <= pc_out + INC (mod 2^XLEN, so it wraps silently), fetch_count += 1 (wraps).
- stall does not block trap, redirect or halt.
- A fetch handshake coinciding with a trap or redirect is still counted: fetch_count increments and pc_prev updates, but pc_out takes the trap/redirect value.
- HALT:
  - pc_valid=0 and halted=1.
  - trap_req: pc_out <= TRAP_VECTOR, then go to RUN.
  - redirect_valid: pc_out <= target, stay in HALT.
  - resume_req (with no trap): go to RUN.
  - halt_req is ignored.
- pc_valid drops only on HALT or reset.

## Timing

- All outputs are registered; there is no combinational input→output path.
- Redirect or trap sampled at edge N: pc_out shows the new value after edge N (1-cycle latency).
- After reset deassertion, the first edge enters BOOT→RUN and pc_valid=1; the first fetch can be accepted at the second edge.
- halt_req at edge N: pc_valid=0 after N. resume_req at edge M: pc_valid=1 after M.
- misalign_err is high for exactly the cycle following the offending edge.

## Configuration

- PC_MISALIGN_TRAP_EN defined: a redirect_target with target[1:0]≠0 makes pc_out <= TRAP_VECTOR and pulses misalign_err.
- PC_MISALIGN_TRAP_EN undefined: target[1:0] is forced to 0 and loaded; misalign_err is tied to 0.

## Structure

- Shared package pc_pkg holds:
  - state encoding constants PC_S_BOOT=2'd0, PC_S_RUN=2'd1, PC_S_HALT=2'd2;
  - the default RESET_VECTOR, TRAP_VECTOR and INC constants.
- One sub-module, pc_next_sel: combinational priority mux producing the next pc, next state and the misalign flag. The top module holds the registers and fetch_count.

## Test plan

- Reset, release, hold fetch_ready=1 for 3 cycles → pc_valid rises one cycle after release; pc_out goes 0x0, 0x4, 0x8, 0xC; fetch_count=3.
- stall=1 with fetch_ready=1 → pc_out holds. redirect_valid with target 0x200 during stall → pc_out=0x200 the next cycle.
- trap_req and redirect_valid (0x80) in the same cycle → pc_out=0x100. fetch_ready=0 throughout → fetch_count unchanged.
- halt_req → pc_valid=0, halted=1. Redirect 0x40 while halted → pc_out=0x40, still halted. resume_req → pc_valid=1, then advance to 0x44.
- Redirect to 0x202:
  - with PC_MISALIGN_TRAP_EN → pc_out=0x100 and misalign_err is a one-cycle pulse;
  - without it → pc_out=0x200 and misalign_err=0.
- Redirect to 0xFFFF_FFFC, then accept one fetch → pc_out wraps to 0x0. Assert reset mid-halt → all outputs return to their reset values immediately.
